// File: rtl/spi_acq_pkg.sv
// spi_acq_pkg: shared state encoding, default sizes and counter-width helpers
package spi_acq_pkg;

    typedef enum logic [1:0] {IDLE, SELECT, SETTLE, CAPTURE} state_t;

    localparam int DEF_DATA_WIDTH    = 12;
    localparam int DEF_SAMPLE_DIV    = 1000;
    localparam int DEF_XFER_CYCLES   = 32;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_DEPTH         = 8;

    // Width able to hold 0..n-1, never below one bit
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_DIV_W   = cnt_w(DEF_SAMPLE_DIV);
    localparam int DEF_PHASE_W = cnt_w(DEF_XFER_CYCLES > DEF_SETTLE_CYCLES ? DEF_XFER_CYCLES : DEF_SETTLE_CYCLES);
    localparam int DEF_LEVEL_W = $clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/spi_acq_ctrl_if.sv
// spi_acq_ctrl_if: SPI select/data, sample stream and overflow signals of the acquisition block
interface spi_acq_ctrl_if
    import spi_acq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);

    localparam int LW = $clog2(DEPTH + 1);

    logic                  enable;
    logic                  ssel_in;
    logic [DATA_WIDTH-1:0] d_reg_master;
    logic [DATA_WIDTH-1:0] sample_data;
    logic                  sample_valid;
    logic                  sample_ready;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic                  clear_ovf;

    modport slave (
        input  enable, d_reg_master, sample_ready, clear_ovf,
        output ssel_in, sample_data, sample_valid, level, overflow
    );

    modport master (
        output enable, d_reg_master, sample_ready, clear_ovf,
        input  ssel_in, sample_data, sample_valid, level, overflow
    );

endinterface

// File: rtl/spi_sample_fifo.sv
// spi_sample_fifo: first-word-fall-through sample buffer; head word holds its last value when empty
module spi_sample_fifo
    import spi_acq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int AW        = cnt_w(DEPTH),
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic [LW-1:0]         o_level,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [LW-1:0]         r_level;
    logic [DATA_WIDTH-1:0] r_last;
    logic                  w_wr;
    logic                  w_rd;

    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_dout  = o_empty ? r_last : r_mem[r_rd];
    assign w_rd    = i_pop && !o_empty;
    // A pop frees the slot being written, so a full FIFO still accepts that push
    assign w_wr    = i_push && (!o_full || w_rd);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_last  <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + AW'(1);
            if (w_rd) begin
                r_rd   <= r_rd + AW'(1);
                r_last <= r_mem[r_rd];
            end
            r_level <= r_level + LW'(w_wr) - LW'(w_rd);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/spi_acq_ctrl.sv
// spi_acq_ctrl: periodic SPI conversion sequencer feeding a sample FIFO with sticky overflow
module spi_acq_ctrl
    import spi_acq_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
    parameter int XFER_CYCLES   = DEF_XFER_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DEPTH         = DEF_DEPTH
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    spi_acq_ctrl_if.slave io_bus
);

    localparam int PW = cnt_w(SAMPLE_DIV);
    localparam int CW = cnt_w(XFER_CYCLES > SETTLE_CYCLES ? XFER_CYCLES : SETTLE_CYCLES);

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_pcnt;
    logic [CW-1:0] r_cnt;
    logic          r_ssel;
    logic          r_ovf;
    logic          w_tick;
    logic          w_last;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;

    assign w_tick = io_bus.enable && r_pcnt == PW'(SAMPLE_DIV - 1);
    assign w_last = (r_state == SELECT) ? r_cnt == CW'(XFER_CYCLES - 1) : r_cnt == CW'(SETTLE_CYCLES - 1);
    assign w_pop  = !w_empty && io_bus.sample_ready;
    assign w_drop = w_push && w_full && !w_pop;

    assign io_bus.ssel_in      = r_ssel;
    assign io_bus.sample_valid = !w_empty;
    assign io_bus.overflow     = r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        case (r_state)
            IDLE:    if (w_tick) w_next = SELECT;
            SELECT:  if (w_last) w_next = SETTLE;
            SETTLE:  if (w_last) w_next = CAPTURE;
            CAPTURE: begin
                w_push = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Select is registered from the next state so it is glitch-free and aligned to the state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt <= '0;
            r_cnt  <= '0;
            r_ssel <= 1'b1;
            r_ovf  <= 1'b0;
        end else begin
            r_pcnt <= (!io_bus.enable || w_tick) ? '0 : r_pcnt + PW'(1);
            r_cnt  <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + CW'(1);
            r_ssel <= w_next != SELECT;
            r_ovf  <= w_drop || (r_ovf && !io_bus.clear_ovf);
        end
    end

    spi_sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_din   (io_bus.d_reg_master),
        .i_pop   (w_pop),
        .o_dout  (io_bus.sample_data),
        .o_level (io_bus.level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
